phy_tx_arbiter: RTL and testbench

PHY_TX_ARBITER -- requirements
Module: phy_tx_arbiter

---
 rtl/phy_tx_arbiter.sv | 118 +++++++++++
 tb/tb_phy_tx_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/phy_tx_arbiter.sv
// Two-requester TX arbiter in front of a PHY: link bring-up FSM plus
// burst-limited arbitration, with a registered output word stage.
module phy_tx_arbiter #(
    parameter int INIT_CYCLES = 4,
    parameter int BURST_MAX   = 4
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] data_in0,
    input  logic        valid_in0,
    output logic        ready0,
    input  logic [31:0] data_in1,
    input  logic        valid_in1,
    output logic        ready1,
    output logic [31:0] data_input,
    output logic        valid,
    output logic        active,
    output logic        grant_id
);
    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_ACTIVE, ST_IDLE} state_t;

    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t      state_q, state_d;
    logic [7:0]  init_cnt_q, init_cnt_d;
    logic        last_q, last_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
    logic        gid_q, gid_d;
    logic        link_ok, sel, xfer;

    // Ready depends on the current enable so a falling enable blocks the transfer in the same cycle.
    always_comb begin
        link_ok = (state_q == ST_ACTIVE) && enable;
        if (valid_in0 && valid_in1)
            sel = (burst_cnt_q < BURST_LIM) ? last_q : ~last_q;
        else
            sel = valid_in1;
        xfer   = link_ok && (valid_in0 || valid_in1);
        ready0 = xfer && !sel;
        ready1 = xfer && sel;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        gid_d       = gid_q;
        active_d    = link_ok;

        case (state_q)
            ST_RESET: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST && enable)
                    state_d = ST_ACTIVE;
                else if (init_cnt_q != INIT_LAST)
                    init_cnt_d = init_cnt_q + 8'd1;
            end
            ST_ACTIVE: if (!enable) state_d = ST_IDLE;
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (xfer) begin
            data_d  = sel ? data_in1 : data_in0;
            valid_d = 1'b1;
            gid_d   = sel;
            if (sel == last_q) begin
                if (burst_cnt_q < BURST_LIM) burst_cnt_d = burst_cnt_q + 4'd1;
            end else begin
                last_d      = sel;
                burst_cnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            init_cnt_q  <= '0;
            last_q      <= 1'b1;
            burst_cnt_q <= BURST_LIM;
            data_q      <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            gid_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            gid_q       <= gid_d;
        end
    end

    assign data_input = data_q;
    assign valid      = valid_q;
    assign active     = active_q;
    assign grant_id   = gid_q;
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Bench for phy_tx_arbiter: directed bring-up/burst/reset steps plus a random
// phase, all checked against a cycle-level model of the link and arbitration rules.
module tb_phy_tx_arbiter;
    localparam int INIT_CYCLES = 4;
    localparam int BURST_MAX   = 2;
    localparam int M_OFF = 0, M_WARM = 1, M_UP = 2, M_DOWN = 3;

    logic        clk_f = 1'b0, reset = 1'b0, enable = 1'b0;
    logic [31:0] data_in0 = '0, data_in1 = '0;
    logic        valid_in0 = 1'b0, valid_in1 = 1'b0;
    logic        ready0, ready1, valid, active, grant_id;
    logic [31:0] data_input;

    phy_tx_arbiter #(.INIT_CYCLES(INIT_CYCLES), .BURST_MAX(BURST_MAX)) dut (
        .clk_f(clk_f), .reset(reset), .enable(enable),
        .data_in0(data_in0), .valid_in0(valid_in0), .ready0(ready0),
        .data_in1(data_in1), .valid_in1(valid_in1), .ready1(ready1),
        .data_input(data_input), .valid(valid), .active(active), .grant_id(grant_id)
    );

    always #5 clk_f = ~clk_f;

    int tests = 0, fails = 0;
    int n0 = 0, n1 = 0;            // index of next unsent word per requester
    int m_mode, m_warm, m_last, m_burst;
    logic [31:0] m_data;
    logic m_valid, m_gid, m_active;
    int glog[$];
    int pat[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_warm = 0; m_last = 1; m_burst = BURST_MAX;
        m_data = '0; m_valid = 1'b0; m_gid = 1'b0; m_active = 1'b0;
    endtask

    task automatic drive(input bit v0, input bit v1, input bit en);
        valid_in0 = v0; valid_in1 = v1; enable = en;
        data_in0 = 32'hA000_0000 + 32'(n0);
        data_in1 = 32'hB000_0000 + 32'(n1);
    endtask

    // One clock: check ready against the model's grant, advance the model, check outputs.
    task automatic cyc();
        int g;
        #1;
        g = -1;
        if (m_mode == M_UP && enable) begin
            if (valid_in0 && valid_in1) g = (m_burst < BURST_MAX) ? m_last : 1 - m_last;
            else if (valid_in0) g = 0;
            else if (valid_in1) g = 1;
        end
        chk("ready0", 32'(ready0), 32'(g == 0));
        chk("ready1", 32'(ready1), 32'(g == 1));
        m_active = (m_mode == M_UP) && enable;
        if (g >= 0) begin
            m_data  = (g == 1) ? 32'hB000_0000 + 32'(n1) : 32'hA000_0000 + 32'(n0);
            m_valid = 1'b1;
            m_gid   = g[0];
            if (g == m_last) m_burst = (m_burst + 1 > BURST_MAX) ? BURST_MAX : m_burst + 1;
            else begin m_last = g; m_burst = 1; end
            if (g == 1) n1++; else n0++;
            glog.push_back(g);
        end else m_valid = 1'b0;
        case (m_mode)
            M_OFF:  begin m_mode = M_WARM; m_warm = 0; end
            M_WARM: if (m_warm == INIT_CYCLES - 1 && enable) m_mode = M_UP;
                    else if (m_warm < INIT_CYCLES - 1) m_warm++;
            M_UP:   if (!enable) m_mode = M_DOWN;
            default: if (enable) begin m_mode = M_WARM; m_warm = 0; end
        endcase
        @(posedge clk_f); #1;
        chk("valid", 32'(valid), 32'(m_valid));
        chk("data_input", data_input, m_data);
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("active", 32'(active), 32'(m_active));
        @(negedge clk_f);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, data_input, 32'h0);
        chk({tag, "_valid"}, 32'(valid), 32'h0);
        chk({tag, "_active"}, 32'(active), 32'h0);
        chk({tag, "_gid"}, 32'(grant_id), 32'h0);
        chk({tag, "_ready0"}, 32'(ready0), 32'h0);
        chk({tag, "_ready1"}, 32'(ready1), 32'h0);
    endtask

    initial begin
        int edges;
        model_reset();
        // Reset held with both requesters asking: everything stays quiet.
        drive(1, 1, 1);
        @(posedge clk_f); @(posedge clk_f); #1;
        chk_zero("rst");
        @(negedge clk_f);
        reset = 1'b1;

        // Bring-up with enable held, then both streaming.
        edges = 0;
        for (int i = 0; i < 20 && !active; i++) begin drive(1, 1, 1); cyc(); edges++; end
        chk("active_edges", 32'(edges), 32'd6);
        for (int i = 0; i < 8; i++) begin drive(1, 1, 1); cyc(); end
        for (int i = 0; i < 8; i++) chk("burst_pat", 32'(glog[i]), 32'(pat[i]));

        // Single requester: no burst limit.
        for (int i = 0; i < 6; i++) begin drive(1, 0, 1); cyc(); end

        // Enable drop mid-stream, then re-init and resume.
        for (int i = 0; i < 3; i++) begin drive(1, 1, 0); cyc(); end
        for (int i = 0; i < 10; i++) begin drive(1, 1, 1); cyc(); end

        // Random traffic with occasional enable drops.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) != 0);
            cyc();
        end

        // Reset while an output word is in flight.
        for (int i = 0; i < 20 && !(m_mode == M_UP && m_valid); i++) begin drive(1, 1, 1); cyc(); end
        chk("pre_rst_valid", 32'(valid), 32'h1);
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk_f); @(posedge clk_f); @(negedge clk_f);
        reset = 1'b1;
        glog.delete();
        for (int i = 0; i < 20 && glog.size() == 0; i++) begin drive(1, 1, 1); cyc(); end
        chk("post_rst_grants", 32'(glog.size() > 0), 32'h1);
        if (glog.size() > 0) chk("post_rst_first", 32'(glog[0]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
